// File: rtl/if_stage_pkg.sv
// Shared CPU pipeline definitions: bus widths and reset vector used by the
// fetch, decode and execute stages.
package if_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
   localparam int          FS_TO_DS_BUS_WD  = 64;
   localparam int          BR_BUS_WD        = 33;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
   } br_bus_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fs_to_ds_t;

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, one-entry stall buffer for the
// synchronous inst SRAM, and a redirect latch for branches seen during a stall.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ds_allowin,
   input  logic [BR_BUS_WD-1:0]       br_bus,
   output logic                       fs_to_ds_valid,
   output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
   output logic                       inst_sram_en,
   output logic                       inst_sram_we,
   output logic [31:0]                inst_sram_addr,
   output logic [31:0]                inst_sram_wdata,
   input  logic [31:0]                inst_sram_rdata
);

   br_bus_t     br;
   logic        fs_valid;
   logic [31:0] fs_pc;
   logic [31:0] fs_inst;
   logic        buf_valid;
   logic [31:0] inst_buf;
   logic        br_pend;
   logic [31:0] br_pend_target;
   logic        fs_allowin;
   logic        redirect;
   logic [31:0] nextpc;
   fs_to_ds_t   fs_out;

   assign br         = br_bus;
   assign redirect   = br.taken || br_pend;
   assign fs_allowin = !fs_valid || ds_allowin;

   always_comb begin
      nextpc = fs_pc + 32'd4;
      if (br_pend)
         nextpc = br_pend_target;
      else if (br.taken)
         nextpc = br.target;
   end

   assign inst_sram_en    = !reset && fs_allowin;
   assign inst_sram_we    = 1'b0;
   assign inst_sram_addr  = nextpc;
   assign inst_sram_wdata = 32'd0;

   // rdata is only valid the cycle after the fetch; the buffer covers longer stalls
   assign fs_inst        = buf_valid ? inst_buf : inst_sram_rdata;
   assign fs_out         = '{pc: fs_pc, inst: fs_inst};
   assign fs_to_ds_valid = fs_valid && !redirect;
   assign fs_to_ds_bus   = reset ? '0 : fs_out;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fs_valid       <= 1'b0;
         fs_pc          <= RESET_PC - 32'd4;
         buf_valid      <= 1'b0;
         inst_buf       <= '0;
         br_pend        <= 1'b0;
         br_pend_target <= '0;
      end else begin
         if (inst_sram_en) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
         end

         if (fs_allowin || redirect)
            buf_valid <= 1'b0;
         else if (fs_valid && !ds_allowin && !buf_valid) begin
            buf_valid <= 1'b1;
            inst_buf  <= inst_sram_rdata;
         end

         // A branch arriving while a pending target is being fetched stays
         // pending so the newest redirect is the one that lands.
         if (br.taken && (!fs_allowin || br_pend)) begin
            br_pend        <= 1'b1;
            br_pend_target <= br.target;
         end else if (fs_allowin)
            br_pend <= 1'b0;
      end
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c00_0000, the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port ds_allowin  in  1  decode stage can accept an instruction this cycle.
REQ-005 SHALL have port br_bus  in  33  {br_taken, br_target[31:0]} from decode; br_taken is a one-cycle pulse.
REQ-006 SHALL have port fs_to_ds_valid  out  1  fs_to_ds_bus holds a valid instruction.
REQ-007 SHALL have port fs_to_ds_bus  out  64  {fs_pc[31:0], fs_inst[31:0]}.
REQ-008 SHALL have ports inst_sram_en out 1, inst_sram_we out 1, inst_sram_addr out 32, inst_sram_wdata out 32, inst_sram_rdata in 32.

Function
REQ-009 SHALL treat inst SRAM as synchronous: address with en=1 in cycle N gives rdata in cycle N+1 only; rdata is undefined afterwards.
REQ-010 SHALL drive inst_sram_we=0 and inst_sram_wdata=0 constantly.
REQ-011 SHALL compute nextpc = br_pend ? br_pend_target : br_taken ? br_target : fs_pc+4, using 32-bit wrap-around addition.
REQ-012 SHALL define fs_allowin = !fs_valid || ds_allowin; define inst_sram_en = !reset && fs_allowin; drive inst_sram_addr = nextpc.
REQ-013 SHALL, on each cycle with inst_sram_en=1, load fs_pc<=nextpc and set fs_valid<=1, giving one-cycle fetch latency.
REQ-014 SHALL drive fs_to_ds_valid = fs_valid && !br_taken && !br_pend, so that the wrong-path instruction behind a taken branch never reaches decode.
REQ-015 SHALL select fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
REQ-016 SHALL capture inst_sram_rdata into inst_buf and set buf_valid in the first cycle where fs_valid=1, ds_allowin=0, buf_valid=0, and no redirect is active.
REQ-017 SHALL clear buf_valid whenever fs_allowin=1 or a redirect (br_taken or br_pend) is active.
REQ-018 SHALL hold a redirect that arrives while fs_allowin=0: set br_pend=1 and br_pend_target=br_target; clear br_pend in the cycle the fetch of br_pend_target is issued.
REQ-019 SHALL let a later br_taken overwrite a pending redirect (last redirect wins).
REQ-020 SHALL, while fs_allowin=0, hold fs_pc, fs_valid and fs_to_ds_bus stable, except when a redirect suppresses valid.
REQ-021 SHALL have br_taken and ds_allowin=1 in the same cycle fetch br_target next, with no bubble beyond the one cancelled slot.

Reset
REQ-022 SHALL, while reset=1: clear fs_valid, buf_valid and br_pend; load fs_pc=RESET_PC-4; drive inst_sram_en=0, fs_to_ds_valid=0 and fs_to_ds_bus=0.
REQ-023 SHALL issue its first fetch at RESET_PC in the first cycle after reset deasserts.
REQ-024 SHALL discard any in-flight fetch, buffered instruction or pending redirect when reset asserts mid-operation.

Structure
REQ-025 SHALL take RESET_PC default, FS_TO_DS_BUS_WD=64 and BR_BUS_WD=33 from the shared CPU definitions package, which decode and execute stages also use.
REQ-026 SHALL be a single module with no sub-modules; the PC register, instruction buffer and redirect latch are inline.

Verification
REQ-027 Release reset with ds_allowin=1 and no branches -> addresses 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles; fs_to_ds_valid first rises one cycle after the first fetch, with matching pc/inst.
REQ-028 Hold ds_allowin=0 for 3 cycles while inst 0x02800421 is at pc 0x1c000004, and let SRAM return garbage -> bus holds {0x1c000004, 0x02800421} throughout; inst_sram_en=0; fetch resumes at 0x1c000008.
REQ-029 Pulse br_taken with target 0x1c000100 while ds_allowin=1 -> fs_to_ds_valid=0 that cycle; next address 0x1c000100; next valid pc 0x1c000100.
REQ-030 Pulse br_taken with target 0x1c000200 while ds_allowin=0, then raise ds_allowin 2 cycles later -> no wrong-path valid; first fetch after the stall is 0x1c000200.
REQ-031 Assert reset asynchronously mid-stall with buf_valid=1 and br_pend=1 -> outputs go to reset values immediately; after release, fetch restarts at 0x1c000000.
REQ-032 Run fs_pc at 0xfffffffc without branches -> next fetch address is 0x00000000.
